// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants for the timing generator, colour mux and game engines
package vga_timing_pkg;
    localparam int COORD_W = 10;
    localparam int H_ACTIVE = 640;
    localparam int H_FP = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter with wrap flag and a sync decode registered on the load edge
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP = 16,
    parameter int SYNC = 96,
    parameter int BP = 48,
    parameter bit SYNC_POL = 1'b0,
    parameter int W = COORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] idx,
    output logic         wrap,
    output logic         active_nxt,
    output logic         sync
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT = W'(ACTIVE);
    localparam logic [W-1:0] S0 = W'(ACTIVE + FP);
    localparam logic [W-1:0] S1 = W'(ACTIVE + FP + SYNC);
    if (TOTAL > (1 << W)) begin : g_bad_total
        $error("vga_axis_counter: TOTAL does not fit in W bits");
    end
    logic [W-1:0] cnt_q, cnt_d, idx_q, idx_d;
    logic sync_q, sync_d;
    assign wrap = cnt_q == LAST;
    assign idx = idx_q;
    assign sync = sync_q;
    assign active_nxt = cnt_d < ACT;
    // the index register holds 0 until the first enable while the counter sits on LAST
    always_comb begin
        cnt_d = en ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        idx_d = en ? cnt_d : idx_q;
        sync_d = en ? ((cnt_d >= S0 && cnt_d < S1) ? SYNC_POL : ~SYNC_POL) : sync_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LAST;
            idx_q <= '0;
            sync_q <= ~SYNC_POL;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            sync_q <= sync_d;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider, h/v raster counters, registered syncs, display enable and event pulses
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP = vga_timing_pkg::H_FP,
    parameter int H_SYNC = vga_timing_pkg::H_SYNC,
    parameter int H_BP = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP = vga_timing_pkg::V_FP,
    parameter int V_SYNC = vga_timing_pkg::V_SYNC,
    parameter int V_BP = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] xIndex,
    output logic [COORD_W-1:0] yIndex,
    output logic               displayEnable,
    output logic               hsync,
    output logic               vsync,
    output logic               pixelTick,
    output logic               lineStart,
    output logic               frameStart,
    output logic               frameEnd
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] V_LAST_ACTIVE = COORD_W'(V_ACTIVE - 1);
    if (CLK_DIV < 1 || H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_cfg
        $error("vga_timing_gen: unsupported timing configuration");
    end
    logic [DIV_W-1:0] div_q, div_d;
    logic tick, h_wrap, v_wrap, h_act_nxt, v_act_nxt;
    logic de_q, de_d, pix_q, pix_d, line_q, line_d, fs_q, fs_d, fe_q, fe_d;
    assign tick = div_q == DIV_LAST;
    // yIndex tracks the vertical counter, so V_ACTIVE-1 on a line wrap means entering vblank
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        de_d = tick ? (h_act_nxt & v_act_nxt) : de_q;
        pix_d = tick;
        line_d = tick & h_wrap;
        fs_d = line_d & v_wrap;
        fe_d = line_d & (yIndex == V_LAST_ACTIVE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            de_q <= 1'b0;
            pix_q <= 1'b0;
            line_q <= 1'b0;
            fs_q <= 1'b0;
            fe_q <= 1'b0;
        end else begin
            div_q <= div_d;
            de_q <= de_d;
            pix_q <= pix_d;
            line_q <= line_d;
            fs_q <= fs_d;
            fe_q <= fe_d;
        end
    end
    assign displayEnable = de_q;
    assign pixelTick = pix_q;
    assign lineStart = line_q;
    assign frameStart = fs_q;
    assign frameEnd = fe_q;
    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL), .W(COORD_W)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .en(tick), .idx(xIndex), .wrap(h_wrap),
        .active_nxt(h_act_nxt), .sync(hsync)
    );
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL), .W(COORD_W)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .en(tick & h_wrap), .idx(yIndex), .wrap(v_wrap),
        .active_nxt(v_act_nxt), .sync(vsync)
    );
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream raster timing source for the display path.
- Divides the system clock to a pixel rate.
- Runs horizontal and vertical counters and produces registered hsync/vsync.
- Drives the pixel coordinates and display-enable consumed by the colour-mux stage.
- Emits single-cycle frame and line event pulses, used by game-logic engines for per-frame updates.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1); 100 MHz -> 25 MHz pixel
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
xIndex  output  10  current horizontal pixel count (0..H_TOTAL-1)
yIndex  output  10  current line count (0..V_TOTAL-1)
displayEnable  output  1  high while xIndex<H_ACTIVE and yIndex<V_ACTIVE
hsync  output  1  horizontal sync, level per SYNC_POL
vsync  output  1  vertical sync, level per SYNC_POL
pixelTick  output  1  one-clk pulse when counters advance
lineStart  output  1  one-clk pulse when xIndex becomes 0
frameStart  output  1  one-clk pulse when (xIndex,yIndex) becomes (0,0)
frameEnd  output  1  one-clk pulse when yIndex becomes V_ACTIVE with xIndex 0 (vblank entry)

Behaviour:
- Single clock domain, clk. rst_n is asynchronous assert and is sampled synchronously on deassert by the surrounding reset logic.
- Divider:
  - divCnt counts 0..CLK_DIV-1 and wraps.
  - tick = (divCnt==CLK_DIV-1).
  - With CLK_DIV=1, tick is constantly high.
- Counters advance only on tick.
  - h wraps H_TOTAL-1 -> 0.
  - On the h wrap, v increments; v wraps V_TOTAL-1 -> 0.
  - No other wrap points.
- Reset values:
  - divCnt=0, h=H_TOTAL-1, v=V_TOTAL-1, so the first tick lands on (0,0).
  - Outputs: xIndex=0, yIndex=0, displayEnable=0, hsync=vsync=~SYNC_POL, pixelTick=lineStart=frameStart=frameEnd=0.
- All outputs are registered.
  - On the edge where the counters load (h',v'), the outputs load the decode of (h',v') on that same edge. xIndex/yIndex therefore always equal the internal counters; after reset they equal them from the first tick.
  - No combinational path from counters to output pins.
- Decode, with h,v the new values:
  - displayEnable = h<H_ACTIVE && v<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491. vsync changes only together with an h wrap.
- Event pulses:
  - Each of pixelTick, lineStart, frameStart, frameEnd is high for exactly one clk, on the edge the counters load.
  - lineStart when h'=0; frameStart when h'=0,v'=0; frameEnd when h'=0,v'=V_ACTIVE.
  - All pulses are 0 on non-tick cycles.
  - frameStart and lineStart coincide at (0,0).
- Reset mid-operation: all state returns immediately (asynchronously) to reset values. The next frame starts cleanly CLK_DIV clocks after release, with no partial sync pulse.
- Widths: counters are 10 bits. Elaboration fails if H_TOTAL>1024, V_TOTAL>1024 or CLK_DIV<1. Divider width is $clog2(CLK_DIV) with a minimum of 1.

Decomposition:
- Shared package/include vga_timing_pkg holds:
  - the 640x480@60 constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL);
  - derived sync start/end constants;
  - COORD_W=10.
- The colour mux and the game engines use the same package.
- One sub-module: vga_axis_counter (parameterised ACTIVE/FP/SYNC/BP). It contains a counter with enable, a wrap output and a registered sync/active decode.
  - It is instantiated twice. Horizontal: enable=tick. Vertical: enable=tick & hWrap.
- The top level adds the divider and the event-pulse registers.

Test Plan:
- Reset: hold rst_n=0 for 10 clk -> xIndex=0, yIndex=0, displayEnable=0, hsync=vsync=1, all pulses 0. Release -> after 4 clk: pixelTick, lineStart, frameStart all 1 for one clk; displayEnable=1; x=0, y=0.
- Horizontal timing (CLK_DIV=4): from (0,0) -> displayEnable falls on the edge x becomes 640. hsync goes 0 at x=656 and back to 1 at x=752. x wraps 799->0 with y 0->1 and lineStart pulse. Line period is 3200 clk.
- Vertical timing: run to y=480 -> frameEnd pulse at (0,480). vsync low for y=490..491 only, i.e. 1600 pixel ticks. displayEnable stays 0 for y>=480.
- Frame wrap: (799,524) -> (0,0) with frameStart. Frame period is exactly 420000 pixel ticks (1,680,000 clk). Exactly one frameStart and one frameEnd per frame.
- Reset mid-line: assert rst_n=0 asynchronously at (300,200) between clock edges -> outputs reach reset values without waiting for clk. After release the sequence restarts as in the reset scenario.
- CLK_DIV=1, SYNC_POL=1 build: pixelTick constantly 1; x advances every clk; hsync is high (asserted) only for x=656..751.
